// File: rtl/reg_file_param.sv
// Parametrised register file: one-hot write decode, DEPTH x WIDTH storage,
// two combinational read ports with optional hardwired-zero register and write bypass.
module reg_file_param #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned ADDR_BITS = 5,
  parameter bit          ZERO_EN   = 1'b1,
  parameter int unsigned ZERO_IDX  = (2 ** ADDR_BITS) - 1,
  parameter bit          BYPASS    = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    regWrite,
  input  logic [ADDR_BITS-1:0]    writeRegister,
  input  logic [WIDTH-1:0]        writeData,
  input  logic [ADDR_BITS-1:0]    readRegister1,
  input  logic [ADDR_BITS-1:0]    readRegister2,
  output logic [WIDTH-1:0]        readData1,
  output logic [WIDTH-1:0]        readData2,
  output logic [(2**ADDR_BITS)-1:0] writeStrobe
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] ZERO_ADDR = ADDR_BITS'(ZERO_IDX);

  logic [DEPTH-1:0] sel;
  logic [WIDTH-1:0] regs [DEPTH];
  logic             byp1;
  logic             byp2;
  logic             zero1;
  logic             zero2;

  // One-hot write decode; the hardwired-zero slot never gets selected
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      sel[i] = regWrite && (writeRegister == ADDR_BITS'(i));
      if (ZERO_EN && (i == ZERO_IDX)) begin
        sel[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      writeStrobe <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      writeStrobe <= sel;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (sel[i]) begin
          regs[i] <= writeData;
        end
      end
    end
  end

  assign zero1 = ZERO_EN && (readRegister1 == ZERO_ADDR);
  assign zero2 = ZERO_EN && (readRegister2 == ZERO_ADDR);
  assign byp1  = BYPASS && regWrite && (writeRegister == readRegister1);
  assign byp2  = BYPASS && regWrite && (writeRegister == readRegister2);

  // Read priority: reset, zero register, bypass, storage
  always_comb begin
    readData1 = regs[readRegister1];
    if (reset || zero1) begin
      readData1 = '0;
    end else if (byp1) begin
      readData1 = writeData;
    end
  end

  always_comb begin
    readData2 = regs[readRegister2];
    if (reset || zero2) begin
      readData2 = '0;
    end else if (byp2) begin
      readData2 = writeData;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param: default, no-bypass and
// narrow (WIDTH=32, ADDR_BITS=3, ZERO_IDX=0) instances.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [63:0] writeData;
  logic [4:0]  readRegister1;
  logic [4:0]  readRegister2;
  logic [63:0] rd1, rd2, nb_rd1, nb_rd2;
  logic [31:0] ws, nb_ws;

  logic        p_we;
  logic [2:0]  p_wa, p_r1, p_r2;
  logic [31:0] p_wd, p_rd1, p_rd2;
  logic [7:0]  p_ws;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_file_param dut (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeRegister(writeRegister),
    .writeData(writeData), .readRegister1(readRegister1), .readRegister2(readRegister2),
    .readData1(rd1), .readData2(rd2), .writeStrobe(ws)
  );

  reg_file_param #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeRegister(writeRegister),
    .writeData(writeData), .readRegister1(readRegister1), .readRegister2(readRegister2),
    .readData1(nb_rd1), .readData2(nb_rd2), .writeStrobe(nb_ws)
  );

  reg_file_param #(.WIDTH(32), .ADDR_BITS(3), .ZERO_EN(1'b1), .ZERO_IDX(0)) dut_p (
    .clk(clk), .reset(reset), .regWrite(p_we), .writeRegister(p_wa),
    .writeData(p_wd), .readRegister1(p_r1), .readRegister2(p_r2),
    .readData1(p_rd1), .readData2(p_rd2), .writeStrobe(p_ws)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [63:0] d);
    @(negedge clk);
    regWrite      = 1'b1;
    writeRegister = a;
    writeData     = d;
    @(posedge clk);
    #1;
    regWrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    regWrite = 1'b0; writeRegister = '0; writeData = '0;
    readRegister1 = '0; readRegister2 = '0;
    p_we = 1'b0; p_wa = '0; p_wd = '0; p_r1 = '0; p_r2 = '0;
    #12;
    check("rst_ws", 64'(ws), 64'h0);
    check("rst_rd1", rd1, 64'h0);
    check("rst_p_ws", 64'(p_ws), 64'h0);
    reset = 1'b0;

    // Fill, then asynchronous reset mid-cycle
    for (int i = 0; i < 32; i++) do_write(5'(i), 64'(i * 32'h1111));
    readRegister1 = 5'd5; readRegister2 = 5'd30;
    #1;
    check("fill_r5", rd1, 64'h5555);
    check("fill_r30", rd2, 64'h1_FFFE);
    @(posedge clk); #3;
    reset = 1'b1;
    regWrite = 1'b1; writeRegister = 5'd5; writeData = 64'hDEAD;
    #1;
    check("rst_async_rd1", rd1, 64'h0);
    check("rst_async_rd2", rd2, 64'h0);
    @(posedge clk); #1;
    check("rst_hold_ws", 64'(ws), 64'h0);
    @(negedge clk);
    regWrite = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      readRegister1 = 5'(i); readRegister2 = 5'(i);
      #1;
      check("rst_clear", rd1, 64'h0);
    end
    check("rst_clear_ws", 64'(ws), 64'h0);

    // Write/read all non-zero registers
    for (int i = 0; i < 31; i++) begin
      do_write(5'(i), 64'hA5A5_0000_0000_0000 | 64'(i));
      check("wr_strobe", 64'(ws), 64'(1) << i);
    end
    for (int i = 0; i < 31; i++) begin
      readRegister1 = 5'(i); readRegister2 = 5'(30 - i);
      #1;
      check("rd_pair1", rd1, 64'hA5A5_0000_0000_0000 | 64'(i));
      check("rd_pair2", rd2, 64'hA5A5_0000_0000_0000 | 64'(30 - i));
    end

    // Zero register ignores writes, including via bypass
    @(negedge clk);
    regWrite = 1'b1; writeRegister = 5'd31; writeData = 64'hFFFF_FFFF_FFFF_FFFF;
    readRegister1 = 5'd31; readRegister2 = 5'd30;
    #1;
    check("zero_same", rd1, 64'h0);
    @(posedge clk); #1;
    regWrite = 1'b0;
    #1;
    check("zero_after", rd1, 64'h0);
    check("zero_ws", 64'(ws), 64'h0);
    check("zero_r30", rd2, 64'hA5A5_0000_0000_001E);

    // Bypass vs. no bypass
    do_write(5'd3, 64'h10);
    @(negedge clk);
    regWrite = 1'b1; writeRegister = 5'd3; writeData = 64'h20;
    readRegister1 = 5'd3; readRegister2 = 5'd3;
    #1;
    check("byp_pre1", rd1, 64'h20);
    check("byp_pre2", rd2, 64'h20);
    check("nobyp_pre1", nb_rd1, 64'h10);
    check("nobyp_pre2", nb_rd2, 64'h10);
    @(posedge clk); #1;
    regWrite = 1'b0;
    #1;
    check("byp_post1", rd1, 64'h20);
    check("byp_post2", rd2, 64'h20);
    check("nobyp_post1", nb_rd1, 64'h20);

    // Write disabled for three cycles
    do_write(5'd4, 64'h4);
    check("wd_strobe4", 64'(ws), 64'h10);
    @(negedge clk);
    regWrite = 1'b0; writeRegister = 5'd4; writeData = 64'h55; readRegister1 = 5'd4;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("wd_ws", 64'(ws), 64'h0);
      check("wd_r4", rd1, 64'h4);
    end

    // Narrow instance, zero register at index 0
    @(negedge clk);
    p_we = 1'b1; p_wa = 3'd7; p_wd = 32'hDEADBEEF;
    @(posedge clk); #1;
    p_we = 1'b0; p_r1 = 3'd7;
    #1;
    check("p_r7", 64'(p_rd1), 64'hDEADBEEF);
    check("p_ws7", 64'(p_ws), 64'h80);
    @(negedge clk);
    p_we = 1'b1; p_wa = 3'd0; p_wd = 32'h1234_5678; p_r1 = 3'd0; p_r2 = 3'd7;
    #1;
    check("p_zero_same", 64'(p_rd1), 64'h0);
    @(posedge clk); #1;
    p_we = 1'b0;
    #1;
    check("p_zero_after", 64'(p_rd1), 64'h0);
    check("p_zero_ws", 64'(p_ws), 64'h0);
    check("p_r7_hold", 64'(p_rd2), 64'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised register file, successor to the fixed 5-to-32 write decoder. It combines the one-hot write decode, a DEPTH x WIDTH storage array, two asynchronous read ports, an optional hardwired-zero register and optional write-to-read bypass. It sits in the datapath between instruction decode (register indices) and the ALU/memory stage (operands, write-back).

## Interface
- WIDTH, 64: bits per register.
- ADDR_BITS, 5: index width; DEPTH = 2**ADDR_BITS registers.
- ZERO_EN, 1: 1 = register ZERO_IDX always reads 0 and ignores writes.
- ZERO_IDX, DEPTH-1: index of the hardwired-zero register; must be < DEPTH.
- BYPASS, 1: 1 = same-cycle write data forwarded to a matching read port.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- regWrite  in  1  write enable for this cycle.
- writeRegister  in  ADDR_BITS  write index.
- writeData  in  WIDTH  write data.
- readRegister1  in  ADDR_BITS  read port 1 index.
- readRegister2  in  ADDR_BITS  read port 2 index.
- readData1  out  WIDTH  read port 1 data (combinational).
- readData2  out  WIDTH  read port 2 data (combinational).
- writeStrobe  out  DEPTH  one-hot decoded write select, registered (last committed write).

## Operation
- Decode: sel[i] = regWrite & (writeRegister == i), for all i in 0..DEPTH-1. At most one bit set. If ZERO_EN, sel[ZERO_IDX] is forced to 0.
- Storage: on the rising clk edge, reg[i] <= writeData where sel[i]=1. All other registers hold.
- writeStrobe <= sel on every rising edge. It is all-zero the cycle after a cycle with no write or a write to the zero register.
- Read port n (n = 1, 2), evaluated in priority order:
  - ZERO_EN and readRegisterN == ZERO_IDX: output 0.
  - BYPASS, regWrite=1, writeRegister == readRegisterN, and the index is not the zero register: output writeData.
  - Otherwise: output reg[readRegisterN].
- Both ports are independent and may address the same register. Both may bypass in the same cycle.
- With BYPASS=0, a read of the register being written shows the old value until the edge.
- Out-of-range indices cannot occur, since DEPTH = 2**ADDR_BITS.

## Timing
- Reset, asynchronous and immediate on assertion:
  - all reg[i] = 0;
  - writeStrobe = 0;
  - readData1 and readData2 = 0 while reset is high, regardless of bypass.
- Writes presented with regWrite while reset is high are discarded.
- Reset deassertion: the first write can commit on the first rising edge after deassertion.
- Write latency: 1 edge. Data is visible on a non-bypassed read immediately after the edge.
- Read latency: 0 cycles (combinational from indices, storage, writeData and regWrite).
- Reset asserted mid-write (between edges): the write is lost and the target register reads 0.
- Back-to-back writes to the same index: the last edge wins. Each is visible via bypass in its own cycle.
- regWrite=1 with writeRegister == ZERO_IDX (ZERO_EN=1): no state change and writeStrobe=0. Reads of ZERO_IDX return 0, including via bypass.
- ZERO_EN=0: ZERO_IDX is an ordinary register.

## Test plan
- Reset: fill all 32 registers with i*0x1111, then assert reset asynchronously mid-cycle. Required: readData1/2 = 0 immediately and all registers read 0 after release. writeStrobe = 0.
- Write/read all: write reg[i] = 0xA5A5_0000_0000_0000 | i for i = 0..30, then read pairs (i, 30-i). Required: exact values, and writeStrobe = 1<<i one cycle after each write.
- Zero register: write 0xFFFF_FFFF_FFFF_FFFF to index 31. Required: readData1 = 0 for index 31 in the same cycle and after; writeStrobe = 0; reg[30] unchanged.
- Bypass: reg[3] = 0x10, then same cycle regWrite=1, writeRegister=3, writeData=0x20, readRegister1=3, readRegister2=3. Required: both ports = 0x20 before the edge and 0x20 after. Repeat with BYPASS=0: 0x10 before the edge, 0x20 after.
- Write disabled: regWrite=0, writeRegister=4, writeData=0x55 for 3 cycles. Required: reg[4] keeps its prior value 0x4 and writeStrobe = 0.
- Parametrisation: WIDTH=32, ADDR_BITS=3, ZERO_EN=1, ZERO_IDX=0. Required: write 0xDEADBEEF to index 7 and read back 0xDEADBEEF; a write to index 0 reads back 0.
